// File: rtl/apb_sram_slave.sv
// APB word-addressed SRAM slave with byte strobes, range-checked addresses and WAIT_CYC wait states.
// Latency: pready rises WAIT_CYC cycles into the access phase. Backpressure: the slave inserts wait states; the master holds the transfer until pready.
module apb_sram_slave #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 64,
    parameter int WAIT_CYC = 0
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [31:0]         paddr,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    output logic [DATA_W-1:0]   prdata,
    output logic                pready,
    output logic                pslverr
);

    localparam int NB = DATA_W / 8;
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    typedef struct packed {
        logic [31:0]       addr;
        logic              write;
        logic [DATA_W-1:0] wdata;
        logic [NB-1:0]     strb;
    } req_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;
    req_t              req;
    logic              setup_take;
    logic              enter_done;
    logic              clear_out;
    logic              complete;

    logic [31:0]       acc_addr;
    logic              acc_write;
    logic              acc_ok;
    logic [AW-1:0]     acc_idx;
    logic              wr_ok;
    logic              do_write;
    logic [AW-1:0]     wr_idx;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge pclk) begin
        if (preset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        setup_take = 1'b0;
        enter_done = 1'b0;
        clear_out  = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                // psel with penable already high is not a setup phase and is ignored
                if (psel && !penable) begin
                    setup_take = 1'b1;
                    if (WAIT_CYC == 0) begin
                        state_nxt  = DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (!psel || !penable) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else if (cnt == 4'd0) begin
                    state_nxt  = DONE;
                    enter_done = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE: begin
                if (!psel) begin
                    state_nxt = IDLE;
                    clear_out = 1'b1;
                end else if (penable) begin
                    state_nxt = IDLE;
                    clear_out = 1'b1;
                    complete  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // With no wait states DONE is entered on the setup edge, before the request is latched.
    assign acc_addr  = (state == IDLE) ? paddr  : req.addr;
    assign acc_write = (state == IDLE) ? pwrite : req.write;
    assign acc_ok    = (acc_addr < 32'(DEPTH));
    assign acc_idx   = acc_addr[AW-1:0];

    assign wr_ok    = (req.addr < 32'(DEPTH));
    assign wr_idx   = req.addr[AW-1:0];
    assign do_write = complete && req.write && wr_ok;

    always_ff @(posedge pclk) begin
        if (preset) begin
            req     <= '0;
            prdata  <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
        end else begin
            if (setup_take) begin
                req.addr  <= paddr;
                req.write <= pwrite;
                req.wdata <= pwdata;
                req.strb  <= pstrb;
            end
            if (enter_done) begin
                pready  <= 1'b1;
                pslverr <= !acc_ok;
                prdata  <= (acc_ok && !acc_write) ? mem[acc_idx] : '0;
            end else if (clear_out) begin
                pready  <= 1'b0;
                pslverr <= 1'b0;
                prdata  <= '0;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_write) begin
            for (int b = 0; b < NB; b++) begin
                if (req.strb[b]) begin
                    mem[wr_idx][b*8 +: 8] <= req.wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule
